ahb_sram_ctrl: RTL and testbench

- AHB-Lite slave that sequences a single-port synchronous SRAM macro.
- The SRAM has active-low chip select, a write enable, and registered read data that is valid one cycle after a read is issued.
- Translates AHB address/data-phase pipelining into SRAM accesses and resolves the port conflict when a read follows a write.
- Flags unsupported transfers with a two-cycle ERROR response.
- Sits between the AHB interconnect and the SRAM instance.

---
 rtl/ahb_sram_ctrl.sv | 115 +++++++++++
 tb/tb_ahb_sram_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave in front of a single-port synchronous SRAM with registered read data.
// Handles the read-after-write port conflict with one wait state and signals bad transfers as a two-cycle ERROR.
module ahb_sram_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready_in,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              sram_csen_n,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RD_WAIT, ERR1, ERR2} state_t;

  localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx_p1, idx_nxt;
  logic [ADDR_W-1:0] word;
  logic              acc, bad;

  assign acc  = hsel & hready_in & htrans[1];
  assign word = haddr[ADDR_W+1:2];
  assign bad  = (hsize != 3'b010) | (haddr[1:0] != 2'b00) | (haddr >= LIMIT);

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx_p1;
    hreadyout   = 1'b1;
    hresp       = 1'b0;
    hrdata      = '0;
    sram_csen_n = 1'b1;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_din    = '0;

    case (state)
      WRITE: begin
        sram_csen_n = 1'b0;
        sram_we     = 1'b1;
        sram_addr   = idx_p1;
        sram_din    = hwdata;
      end
      READ: hrdata = sram_dout;
      RD_WAIT: begin
        hreadyout   = 1'b0;
        sram_csen_n = 1'b0;
        sram_addr   = idx_p1;
        state_nxt   = READ;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: hresp = 1'b1;
      default: ;
    endcase

    // A new address phase is taken in every state that is driving hreadyout high.
    if (state != RD_WAIT && state != ERR1) begin
      state_nxt = IDLE;
      if (acc) begin
        if (bad) begin
          state_nxt = ERR1;
        end else if (hwrite) begin
          idx_nxt   = word;
          state_nxt = WRITE;
        end else if (state == WRITE) begin
          idx_nxt   = word;
          state_nxt = RD_WAIT;
        end else begin
          sram_csen_n = 1'b0;
          sram_addr   = word;
          state_nxt   = READ;
        end
      end
    end

    // Reset forces quiet outputs at once so a pending write never reaches the SRAM.
    if (rst) begin
      hreadyout   = 1'b1;
      hresp       = 1'b0;
      hrdata      = '0;
      sram_csen_n = 1'b1;
      sram_we     = 1'b0;
      sram_addr   = '0;
      sram_din    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    idx_p1 <= idx_nxt;
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl: per-cycle vector table plus hand-written reset sequences.
module tb_ahb_sram_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic              hready_in;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hreadyout;
  logic              hresp;
  logic              sram_csen_n;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  ahb_sram_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready_in(hready_in), .hwdata(hwdata),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
    .sram_csen_n(sram_csen_n), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, write when selected with we.
  logic [DATA_W-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 | i;
  always @(posedge clk) begin
    if (!sram_csen_n) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout <= mem[sram_addr];
    end
  end

  logic cafe_written = 1'b0;
  always @(posedge clk)
    if (!sram_csen_n && sram_we && sram_din == 32'hCAFE_F00D) cafe_written <= 1'b1;

  typedef struct {
    string             name;
    logic              sel;
    logic [31:0]       addr;
    logic [1:0]        trans;
    logic              wr;
    logic [2:0]        size;
    logic [DATA_W-1:0] wdata;
    logic              rdy;
    logic              resp;
    logic [DATA_W-1:0] rdata;
    logic              csn;
    logic              we;
    logic [ADDR_W-1:0] saddr;
    logic [DATA_W-1:0] din;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [2:0] W  = 3'b010;

  function automatic vec_t v(string name, logic sel, logic [31:0] addr, logic [1:0] trans,
                             logic wr, logic [2:0] size, logic [31:0] wdata,
                             logic rdy, logic resp, logic [31:0] rdata,
                             logic csn, logic we, logic [5:0] saddr, logic [31:0] din);
    vec_t r;
    r.name = name; r.sel = sel; r.addr = addr; r.trans = trans; r.wr = wr;
    r.size = size; r.wdata = wdata; r.rdy = rdy; r.resp = resp; r.rdata = rdata;
    r.csn = csn; r.we = we; r.saddr = saddr; r.din = din;
    return r;
  endfunction

  function automatic logic [73:0] pack_out(logic rdy, logic resp, logic csn, logic we,
                                           logic [5:0] saddr, logic [31:0] rdata,
                                           logic [31:0] din);
    return {rdy, resp, csn, we, saddr, rdata, din};
  endfunction

  task automatic drive_idle();
    hsel = 1'b0; haddr = '0; htrans = ID; hwrite = 1'b0; hsize = W;
    hready_in = 1'b1; hwdata = '0;
  endtask

  task automatic check_outputs(string name, logic [73:0] exp);
    logic [73:0] act;
    act = pack_out(hreadyout, hresp, sram_csen_n, sram_we, sram_addr, hrdata, sram_din);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got rdy/resp/csn/we/addr/rdata/din=%h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //        name        sel addr     trans wr size wdata         rdy rsp rdata         csn we sa din
    vecs.push_back(v("wr10_ap",  1, 32'h10, NS, 1, W, 0,            1, 0, 0,            1, 0, 0, 0));
    vecs.push_back(v("wr10_dp",  0, 0,      ID, 0, W, 32'hDEADBEEF, 1, 0, 0,            0, 1, 4, 32'hDEADBEEF));
    vecs.push_back(v("idle1",    0, 0,      ID, 0, W, 0,            1, 0, 0,            1, 0, 0, 0));
    vecs.push_back(v("idle2",    0, 0,      ID, 0, W, 0,            1, 0, 0,            1, 0, 0, 0));
    vecs.push_back(v("rd10_ap",  1, 32'h10, NS, 0, W, 0,            1, 0, 0,            0, 0, 4, 0));
    vecs.push_back(v("rd10_dp",  0, 0,      ID, 0, W, 0,            1, 0, 32'hDEADBEEF, 1, 0, 0, 0));
    vecs.push_back(v("raw_wr",   1, 32'h8,  NS, 1, W, 0,            1, 0, 0,            1, 0, 0, 0));
    vecs.push_back(v("raw_rd",   1, 32'h8,  NS, 0, W, 32'h11111111, 1, 0, 0,            0, 1, 2, 32'h11111111));
    vecs.push_back(v("raw_wait", 0, 0,      ID, 0, W, 0,            0, 0, 0,            0, 0, 2, 0));
    vecs.push_back(v("raw_data", 0, 0,      ID, 0, W, 0,            1, 0, 32'h11111111, 1, 0, 0, 0));
    vecs.push_back(v("b2b_rd0",  1, 32'h0,  NS, 0, W, 0,            1, 0, 0,            0, 0, 0, 0));
    vecs.push_back(v("b2b_rd4",  1, 32'h4,  NS, 0, W, 0,            1, 0, 32'hA5000000, 0, 0, 1, 0));
    vecs.push_back(v("b2b_wr8",  1, 32'h8,  NS, 1, W, 0,            1, 0, 32'hA5000001, 1, 0, 0, 0));
    vecs.push_back(v("b2b_wrC",  1, 32'hC,  NS, 1, W, 32'h22222222, 1, 0, 0,            0, 1, 2, 32'h22222222));
    vecs.push_back(v("b2b_end",  0, 0,      ID, 0, W, 32'h33333333, 1, 0, 0,            0, 1, 3, 32'h33333333));
    vecs.push_back(v("rb_rd8",   1, 32'h8,  NS, 0, W, 0,            1, 0, 0,            0, 0, 2, 0));
    vecs.push_back(v("rb_rdC",   1, 32'hC,  NS, 0, W, 0,            1, 0, 32'h22222222, 0, 0, 3, 0));
    vecs.push_back(v("rb_end",   0, 0,      ID, 0, W, 0,            1, 0, 32'h33333333, 1, 0, 0, 0));
    vecs.push_back(v("bad_size", 1, 32'h0,  NS, 0, 3'b001, 0,       1, 0, 0,            1, 0, 0, 0));
    vecs.push_back(v("size_e1",  0, 0,      ID, 0, W, 0,            0, 1, 0,            1, 0, 0, 0));
    vecs.push_back(v("bad_rng",  1, 32'h100,NS, 0, W, 0,            1, 1, 0,            1, 0, 0, 0));
    vecs.push_back(v("rng_e1",   0, 0,      ID, 0, W, 0,            0, 1, 0,            1, 0, 0, 0));
    vecs.push_back(v("bad_algn", 1, 32'h2,  NS, 1, W, 0,            1, 1, 0,            1, 0, 0, 0));
    vecs.push_back(v("algn_e1",  0, 0,      ID, 0, W, 32'h44444444, 0, 1, 0,            1, 0, 0, 0));
    vecs.push_back(v("algn_e2",  0, 0,      ID, 0, W, 0,            1, 1, 0,            1, 0, 0, 0));
    vecs.push_back(v("chk_rd0",  1, 32'h0,  NS, 0, W, 0,            1, 0, 0,            0, 0, 0, 0));
    vecs.push_back(v("chk_dat0", 0, 0,      ID, 0, W, 0,            1, 0, 32'hA5000000, 1, 0, 0, 0));
    vecs.push_back(v("last_wr",  1, 32'hFC, NS, 1, W, 0,            1, 0, 0,            1, 0, 0, 0));
    vecs.push_back(v("last_rd",  1, 32'hFC, NS, 0, W, 32'h0F0F0F0F, 1, 0, 0,            0, 1, 63, 32'h0F0F0F0F));
    vecs.push_back(v("last_wt",  0, 0,      ID, 0, W, 0,            0, 0, 0,            0, 0, 63, 0));
    vecs.push_back(v("last_dat", 1, 32'hFC, ID, 1, W, 0,            1, 0, 32'h0F0F0F0F, 1, 0, 0, 0));
    vecs.push_back(v("htr_idle", 1, 32'hFC, ID, 1, W, 0,            1, 0, 0,            1, 0, 0, 0));

    // Reset state, with a good read presented on the bus during reset.
    rst = 1'b1;
    drive_idle();
    hsel = 1'b1; haddr = 32'h10; htrans = NS;
    @(negedge clk);
    check_outputs("reset_state", pack_out(1, 0, 1, 0, 6'd0, 32'h0, 32'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      hsel = vecs[i].sel; haddr = vecs[i].addr; htrans = vecs[i].trans;
      hwrite = vecs[i].wr; hsize = vecs[i].size; hwdata = vecs[i].wdata;
      hready_in = vecs[i].rdy;
      @(negedge clk);
      check_outputs(vecs[i].name, pack_out(vecs[i].rdy, vecs[i].resp, vecs[i].csn, vecs[i].we,
                                           vecs[i].saddr, vecs[i].rdata, vecs[i].din));
      @(posedge clk); #1;
    end
    drive_idle();
    @(posedge clk); #1;

    // Reset in the middle of a write data phase.
    hsel = 1'b1; haddr = 32'h20; htrans = NS; hwrite = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    hwdata = 32'hCAFE_F00D;
    #1;
    check_outputs("mid_write", pack_out(1, 0, 0, 1, 6'd8, 32'h0, 32'hCAFE_F00D));
    rst = 1'b1;
    #1;
    check_outputs("mid_reset", pack_out(1, 0, 1, 0, 6'd0, 32'h0, 32'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    hwdata = '0;
    @(posedge clk); #1;
    hsel = 1'b1; haddr = 32'h20; htrans = NS; hwrite = 1'b0;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check_val("rst_readback", hrdata, 32'hA500_0008);
    check_val("rst_no_we", {31'b0, cafe_written}, 32'h0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
